alu8_operand_sequencer: RTL and testbench

ALU8_OPERAND_SEQUENCER -- requirements
Module: alu8_operand_sequencer

---
 rtl/alu8_operand_sequencer.sv | 162 ++++++++++++++++
 tb/tb_alu8_operand_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu8_operand_sequencer.sv
// Byte-serial operand sequencer for an 8-bit ALU: collects header/left/right
// bytes, issues the operation, and captures the result on the issue handshake.
module alu8_operand_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic [7:0]       left,
  output logic [7:0]       right,
  output logic [1:0]       mode,
  input  logic [7:0]       alu_result,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [7:0]       last_result,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    HDR   = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2,
    ISSUE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] MAX_C = {CNT_W{1'b1}};

  state_t           state_r;
  state_t           state_n;
  logic [7:0]       left_r;
  logic [7:0]       right_r;
  logic [1:0]       mode_r;
  logic [7:0]       last_result_r;
  logic [CNT_W-1:0] op_count_r;
  logic [CNT_W-1:0] err_count_r;
  logic             in_ready_r;
  logic             op_valid_r;

  logic accept_s;
  logic issue_s;
  logic hdr_ok_s;
  logic ld_mode_s;
  logic ld_left_s;
  logic ld_chain_s;
  logic ld_right_s;
  logic err_inc_s;

  // Reserved header bits must be clear for the header to be accepted as a command.
  function automatic logic header_ok(input logic [7:0] b);
    return (b[7:3] == 5'b00000);
  endfunction

  // Next-state and register-load decode.
  always_comb begin
    state_n    = state_r;
    accept_s   = in_valid & in_ready_r;
    issue_s    = op_valid_r & op_ready;
    hdr_ok_s   = header_ok(in_data);
    ld_mode_s  = 1'b0;
    ld_left_s  = 1'b0;
    ld_chain_s = 1'b0;
    ld_right_s = 1'b0;
    err_inc_s  = 1'b0;
    case (state_r)
      HDR: begin
        if (accept_s && hdr_ok_s) begin
          ld_mode_s = 1'b1;
          if (in_data[2]) begin
            ld_chain_s = 1'b1;
            state_n    = RIGHT;
          end else begin
            state_n = LEFT;
          end
        end else if (accept_s) begin
          err_inc_s = 1'b1;
          state_n   = HDR;
        end else begin
          state_n = HDR;
        end
      end
      LEFT: begin
        if (accept_s) begin
          ld_left_s = 1'b1;
          state_n   = RIGHT;
        end else begin
          state_n = LEFT;
        end
      end
      RIGHT: begin
        if (accept_s) begin
          ld_right_s = 1'b1;
          state_n    = ISSUE;
        end else begin
          state_n = RIGHT;
        end
      end
      ISSUE: begin
        if (issue_s) begin
          state_n = HDR;
        end else begin
          state_n = ISSUE;
        end
      end
      default: begin
        state_n = HDR;
      end
    endcase
  end

  // State, operand, result and counter registers; handshake flags follow the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= HDR;
      left_r        <= 8'h00;
      right_r       <= 8'h00;
      mode_r        <= 2'b00;
      last_result_r <= 8'h00;
      op_count_r    <= '0;
      err_count_r   <= '0;
      in_ready_r    <= 1'b1;
      op_valid_r    <= 1'b0;
    end else begin
      state_r    <= state_n;
      in_ready_r <= (state_n != ISSUE);
      op_valid_r <= (state_n == ISSUE);
      if (ld_mode_s) begin
        mode_r <= in_data[1:0];
      end
      if (ld_chain_s) begin
        left_r <= last_result_r;
      end
      if (ld_left_s) begin
        left_r <= in_data;
      end
      if (ld_right_s) begin
        right_r <= in_data;
      end
      if (issue_s) begin
        last_result_r <= alu_result;
        op_count_r    <= op_count_r + ONE_C;
      end
      // err_count saturates rather than wrapping.
      if (err_inc_s && (err_count_r != MAX_C)) begin
        err_count_r <= err_count_r + ONE_C;
      end
    end
  end

  assign in_ready    = in_ready_r;
  assign op_valid    = op_valid_r;
  assign left        = left_r;
  assign right       = right_r;
  assign mode        = mode_r;
  assign last_result = last_result_r;
  assign op_count    = op_count_r;
  assign err_count   = err_count_r;

endmodule

// File: tb/tb_alu8_operand_sequencer.sv
// Directed bench for alu8_operand_sequencer: a command table plus hand-written
// reset, error-header, stall and counter-width sequences.
module tb_alu8_operand_sequencer;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       op_ready;

  logic       in_ready, op_valid;
  logic [7:0] left, right, last_result, alu_result;
  logic [1:0] mode;
  logic [7:0] op_count, err_count;

  logic       in_ready2, op_valid2;
  logic [7:0] left2, right2, last_result2, alu_result2;
  logic [1:0] mode2;
  logic [1:0] op_count2, err_count2;

  int tests = 0;
  int fails = 0;
  int exp_ops = 0;
  int exp_err = 0;

  function automatic logic [7:0] alu8(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m);
    case (m)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction

  assign alu_result  = alu8(left, right, mode);
  assign alu_result2 = alu8(left2, right2, mode2);

  alu8_operand_sequencer #(.CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .left(left), .right(right), .mode(mode),
    .alu_result(alu_result), .op_valid(op_valid), .op_ready(op_ready),
    .last_result(last_result), .op_count(op_count), .err_count(err_count)
  );

  alu8_operand_sequencer #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready2), .left(left2), .right(right2), .mode(mode2),
    .alu_result(alu_result2), .op_valid(op_valid2), .op_ready(op_ready),
    .last_result(last_result2), .op_count(op_count2), .err_count(err_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] hdr;
    logic [7:0] b1;
    logic [7:0] b2;
    int         nb;
    int         delay;
    logic [7:0] e_left;
    logic [7:0] e_right;
    logic [1:0] e_mode;
    logic [7:0] e_res;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (!in_ready && n < 10) begin
      tick();
      n++;
    end
    check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    exp_ops = 0;
    exp_err = 0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_op_valid"}, {31'd0, op_valid}, 32'd0);
    check({tag, "_left"}, {24'd0, left}, 32'd0);
    check({tag, "_right"}, {24'd0, right}, 32'd0);
    check({tag, "_mode"}, {30'd0, mode}, 32'd0);
    check({tag, "_last_result"}, {24'd0, last_result}, 32'd0);
    check({tag, "_op_count"}, {24'd0, op_count}, 32'd0);
    check({tag, "_err_count"}, {24'd0, err_count}, 32'd0);
  endtask

  task automatic run_cmd(input vec_t v, input string tag);
    send_byte(v.hdr);
    send_byte(v.b1);
    if (v.nb == 2) send_byte(v.b2);
    check({tag, "_op_valid"}, {31'd0, op_valid}, 32'd1);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_left"}, {24'd0, left}, {24'd0, v.e_left});
    check({tag, "_right"}, {24'd0, right}, {24'd0, v.e_right});
    check({tag, "_mode"}, {30'd0, mode}, {30'd0, v.e_mode});
    for (int i = 0; i < v.delay; i++) begin
      tick();
      check({tag, "_stall_op_valid"}, {31'd0, op_valid}, 32'd1);
      check({tag, "_stall_in_ready"}, {31'd0, in_ready}, 32'd0);
      check({tag, "_stall_ops"}, {7'd0, left, right, mode, op_count[6:0]},
            {7'd0, v.e_left, v.e_right, v.e_mode, exp_ops[6:0]});
    end
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    exp_ops++;
    check({tag, "_done_op_valid"}, {31'd0, op_valid}, 32'd0);
    check({tag, "_done_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_last_result"}, {24'd0, last_result}, {24'd0, v.e_res});
    check({tag, "_op_count"}, {24'd0, op_count}, exp_ops & 32'hFF);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //           hdr    b1     b2     nb dly left   right  mode   result
    vecs[0] = '{8'h04, 8'h22, 8'h00, 1, 0, 8'h00, 8'h22, 2'd0, 8'h22}; // chain after reset uses 0
    vecs[1] = '{8'h00, 8'h30, 8'h0B, 2, 0, 8'h30, 8'h0B, 2'd0, 8'h3B};
    vecs[2] = '{8'h07, 8'h40, 8'h00, 1, 0, 8'h3B, 8'h40, 2'd3, 8'h7B};
    vecs[3] = '{8'h01, 8'h05, 8'h07, 2, 4, 8'h05, 8'h07, 2'd1, 8'hFE};
    vecs[4] = '{8'h02, 8'h0F, 8'h3C, 2, 1, 8'h0F, 8'h3C, 2'd2, 8'h0C};
    vecs[5] = '{8'h06, 8'h01, 8'h00, 1, 0, 8'h0C, 8'h01, 2'd2, 8'h00};
    vecs[6] = '{8'h05, 8'h80, 8'h00, 1, 2, 8'h00, 8'h80, 2'd1, 8'h80};
    vecs[7] = '{8'h00, 8'hFF, 8'h02, 2, 0, 8'hFF, 8'h02, 2'd0, 8'h01};

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    op_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    check_reset_state("reset");

    for (int i = 0; i < 8; i++) begin
      run_cmd(vecs[i], $sformatf("vec%0d", i));
    end

    // Bad header is dropped, then an idle gap mid-command holds everything.
    send_byte(8'h80);
    exp_err++;
    check("bad_hdr_err", {24'd0, err_count}, exp_err);
    check("bad_hdr_regs", {14'd0, left, right, mode}, {14'd0, 8'hFF, 8'h02, 2'd0});
    check("bad_hdr_in_ready", {31'd0, in_ready}, 32'd1);
    send_byte(8'h02);
    send_byte(8'h0F);
    repeat (3) tick();
    check("idle_hold", {13'd0, in_ready, op_valid, left, mode, right},
          {13'd0, 1'b1, 1'b0, 8'h0F, 2'd2, 8'h02});
    v = '{8'h02, 8'h0F, 8'h3C, 2, 0, 8'h0F, 8'h3C, 2'd2, 8'h0C};
    send_byte(8'h3C);
    check("err_cmd_op_valid", {31'd0, op_valid}, 32'd1);
    check("err_cmd_ops", {14'd0, left, right, mode}, {14'd0, v.e_left, v.e_right, v.e_mode});
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    exp_ops++;
    check("err_cmd_result", {24'd0, last_result}, 32'h0C);
    check("err_cmd_count", {24'd0, op_count}, exp_ops);

    // Reset while in RIGHT discards the partial command.
    send_byte(8'h00);
    send_byte(8'h11);
    pulse_reset();
    check_reset_state("rst_right");
    v = '{8'h01, 8'h22, 8'h33, 2, 0, 8'h22, 8'h33, 2'd1, 8'hEF};
    run_cmd(v, "after_rst_right");

    // Reset in ISSUE with op_ready high wins over the handshake.
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'hBB);
    check("pre_rst_issue", {31'd0, op_valid}, 32'd1);
    op_ready = 1'b1;
    pulse_reset();
    op_ready = 1'b0;
    check_reset_state("rst_issue");
    v = '{8'h03, 8'h50, 8'h05, 2, 0, 8'h50, 8'h05, 2'd3, 8'h55};
    run_cmd(v, "after_rst_issue");

    // Counter boundaries: wide instance counts exactly, CNT_W=2 wraps/saturates.
    pulse_reset();
    v = '{8'h00, 8'h01, 8'h02, 2, 0, 8'h01, 8'h02, 2'd0, 8'h03};
    for (int i = 0; i < 5; i++) run_cmd(v, $sformatf("cnt_cmd%0d", i));
    for (int i = 0; i < 5; i++) send_byte(8'hF8);
    exp_err = 5;
    check("wide_op_count", {24'd0, op_count}, 32'd5);
    check("wide_err_count", {24'd0, err_count}, exp_err);
    check("narrow_op_count_wrap", {30'd0, op_count2}, 32'd1);
    check("narrow_err_count_sat", {30'd0, err_count2}, 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
